// File: rtl/rdma_pkg.sv
// Shared definitions for the RDMA receive header parser: field offsets,
// parser states and byte-level helpers.
package rdma_pkg;

  localparam int unsigned SRC_OFF  = 0;
  localparam int unsigned DST_OFF  = 2;
  localparam int unsigned LEN_OFF  = 4;
  localparam int unsigned CSUM_OFF = 6;
  localparam int unsigned KEEP_MAX = 64;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAY,
    ST_DRAIN
  } state_t;

  // Lowest nbytes lanes set; callers slice down to their own lane count.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned nbytes);
    logic [KEEP_MAX-1:0] m;
    for (int unsigned i = 0; i < KEEP_MAX; i++) m[i] = (i < nbytes);
    return m;
  endfunction

  function automatic logic [15:0] bswap16(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

endpackage

// File: rtl/rdma_axis_reg.sv
// One-deep AXI-Stream register slice; holds its beat until the consumer takes it.
module rdma_axis_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   s_data,
  input  logic [DATA_W/8-1:0] s_keep,
  input  logic                s_last,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [DATA_W-1:0]   m_data,
  output logic [DATA_W/8-1:0] m_keep,
  output logic                m_last,
  output logic                m_valid,
  input  logic                m_ready
);

  assign s_ready = ~m_valid | m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (s_valid && s_ready) begin
      m_data  <= s_data;
      m_keep  <= s_keep;
      m_last  <= s_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rdma_hdr_parser_p.sv
// RDMA receive header parser: strips the big-endian header, publishes its
// fields and forwards exactly `length` payload bytes; over-length tails are drained.
module rdma_hdr_parser_p
  import rdma_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned HDR_BYTES    = 8,
  parameter int unsigned LEN_INCL_HDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   data_slave,
  input  logic [DATA_W/8-1:0] keep_slave,
  input  logic                valid_slave,
  input  logic                last_slave,
  output logic                ready_slave,
  output logic [DATA_W-1:0]   data_master,
  output logic [DATA_W/8-1:0] keep_master,
  output logic                valid_master,
  output logic                last_master,
  input  logic                ready_master,
  output logic [15:0]         src_port,
  output logic [15:0]         dst_address,
  output logic [15:0]         length,
  output logic [15:0]         checksum,
  output logic                hdr_valid,
  output logic                err_runt,
  output logic                err_short,
  output logic                err_long
);

  localparam int unsigned NB        = DATA_W / 8;
  localparam int unsigned HDR_BEATS = HDR_BYTES / NB;
  localparam int unsigned CNT_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       hdr_cnt, hdr_cnt_nxt;
  logic [16:0]            rem, rem_nxt, take, pay_len;
  logic [HDR_BYTES*8-1:0] hdr_buf, hdr_nxt;
  logic [15:0]            len_field;
  logic [KEEP_MAX-1:0]    mask_full;
  logic [NB-1:0]          ld_keep;
  logic                   accept, ld, ld_last, reg_ready;
  logic                   fire_hdr, fire_runt, fire_short, fire_long;

  assign ready_slave = (state == ST_DRAIN) | reg_ready;
  assign accept      = valid_slave & ready_slave;
  assign take        = (rem > 17'(NB)) ? 17'(NB) : rem;

  always_comb begin
    state_nxt   = state;
    hdr_cnt_nxt = hdr_cnt;
    rem_nxt     = rem;
    hdr_nxt     = hdr_buf;
    fire_hdr    = 1'b0;
    fire_runt   = 1'b0;
    fire_short  = 1'b0;
    fire_long   = 1'b0;
    ld          = 1'b0;
    ld_last     = 1'b0;
    mask_full   = keep_mask(32'(take));
    ld_keep     = keep_slave & mask_full[NB-1:0];

    // The completing header word is merged here so fields latch on the same edge.
    for (int unsigned i = 0; i < HDR_BEATS; i++)
      if (state == ST_HDR && accept && hdr_cnt == CNT_W'(i))
        hdr_nxt[i*DATA_W +: DATA_W] = data_slave;

    len_field = bswap16(hdr_nxt[LEN_OFF*8 +: 16]);
    if (LEN_INCL_HDR != 0)
      pay_len = (17'(len_field) > 17'(HDR_BYTES)) ? 17'(len_field) - 17'(HDR_BYTES) : '0;
    else
      pay_len = 17'(len_field);

    unique case (state)
      ST_HDR: if (accept) begin
        if (hdr_cnt == CNT_W'(HDR_BEATS - 1)) begin
          fire_hdr    = 1'b1;
          hdr_cnt_nxt = '0;
          if (last_slave) begin
            fire_short = (pay_len != '0);
            rem_nxt    = '0;
          end else if (pay_len != '0) begin
            rem_nxt   = pay_len;
            state_nxt = ST_PAY;
          end else begin
            fire_long = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end else if (last_slave) begin
          fire_runt   = 1'b1;
          hdr_cnt_nxt = '0;
        end else begin
          hdr_cnt_nxt = hdr_cnt + CNT_W'(1);
        end
      end
      ST_PAY: if (accept) begin
        ld      = 1'b1;
        ld_last = (rem <= 17'(NB)) | last_slave;
        rem_nxt = rem - take;
        if (rem <= 17'(NB)) begin
          hdr_cnt_nxt = '0;
          if (last_slave) begin
            state_nxt = ST_HDR;
          end else begin
            fire_long = 1'b1;
            state_nxt = ST_DRAIN;
          end
        end else if (last_slave) begin
          fire_short  = 1'b1;
          hdr_cnt_nxt = '0;
          state_nxt   = ST_HDR;
        end
      end
      ST_DRAIN: if (accept && last_slave) begin
        hdr_cnt_nxt = '0;
        state_nxt   = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_HDR;
      hdr_cnt     <= '0;
      rem         <= '0;
      hdr_buf     <= '0;
      src_port    <= '0;
      dst_address <= '0;
      length      <= '0;
      checksum    <= '0;
      hdr_valid   <= 1'b0;
      err_runt    <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      state     <= state_nxt;
      hdr_cnt   <= hdr_cnt_nxt;
      rem       <= rem_nxt;
      hdr_buf   <= hdr_nxt;
      hdr_valid <= fire_hdr;
      err_runt  <= fire_runt;
      err_short <= fire_short;
      err_long  <= fire_long;
      if (fire_hdr) begin
        src_port    <= bswap16(hdr_nxt[SRC_OFF*8 +: 16]);
        dst_address <= bswap16(hdr_nxt[DST_OFF*8 +: 16]);
        length      <= len_field;
        checksum    <= bswap16(hdr_nxt[CSUM_OFF*8 +: 16]);
      end
    end
  end

  rdma_axis_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk    (clk),
    .rst    (rst),
    .s_data (data_slave),
    .s_keep (ld_keep),
    .s_last (ld_last),
    .s_valid(ld),
    .s_ready(reg_ready),
    .m_data (data_master),
    .m_keep (keep_master),
    .m_last (last_master),
    .m_valid(valid_master),
    .m_ready(ready_master)
  );

endmodule

// File: tb/tb_rdma_hdr_parser_p.sv
// Directed-vector bench for rdma_hdr_parser_p: a 64-bit instance driven from a
// table plus hand sequences, and a 32-bit instance for multi-beat headers.
module tb_rdma_hdr_parser_p;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        hdr;
    logic [63:0] fld;   // {src, dst, len, csum}
    logic        ov;
    logic [7:0]  okeep;
    logic        olast;
    logic [2:0]  err;   // {runt, short, long}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_slave, data_master;
  logic [7:0]  keep_slave, keep_master;
  logic        valid_slave, last_slave, ready_slave;
  logic        valid_master, last_master, ready_master;
  logic [15:0] src_port, dst_address, len_f, checksum;
  logic        hdr_valid, err_runt, err_short, err_long;

  logic [31:0] d32_data_s, d32_data_m;
  logic [3:0]  d32_keep_s, d32_keep_m;
  logic        d32_valid_s, d32_last_s, d32_ready_s;
  logic        d32_valid_m, d32_last_m, d32_ready_m;
  logic [15:0] d32_src, d32_dst, d32_len, d32_csum;
  logic        d32_hdr, d32_runt, d32_short, d32_long;

  int          n_run = 0;
  int          n_fail = 0;
  logic [63:0] exp_fld = '0;
  logic [63:0] exp_fld32 = '0;
  vec_t        tbl[$];
  vec_t        tbl32[$];

  always #5 clk = ~clk;

  rdma_hdr_parser_p #(.DATA_W(64), .HDR_BYTES(8), .LEN_INCL_HDR(0)) dut (
    .clk(clk), .rst(rst),
    .data_slave(data_slave), .keep_slave(keep_slave), .valid_slave(valid_slave),
    .last_slave(last_slave), .ready_slave(ready_slave),
    .data_master(data_master), .keep_master(keep_master), .valid_master(valid_master),
    .last_master(last_master), .ready_master(ready_master),
    .src_port(src_port), .dst_address(dst_address), .length(len_f), .checksum(checksum),
    .hdr_valid(hdr_valid), .err_runt(err_runt), .err_short(err_short), .err_long(err_long)
  );

  rdma_hdr_parser_p #(.DATA_W(32), .HDR_BYTES(8), .LEN_INCL_HDR(0)) dut32 (
    .clk(clk), .rst(rst),
    .data_slave(d32_data_s), .keep_slave(d32_keep_s), .valid_slave(d32_valid_s),
    .last_slave(d32_last_s), .ready_slave(d32_ready_s),
    .data_master(d32_data_m), .keep_master(d32_keep_m), .valid_master(d32_valid_m),
    .last_master(d32_last_m), .ready_master(d32_ready_m),
    .src_port(d32_src), .dst_address(d32_dst), .length(d32_len), .checksum(d32_csum),
    .hdr_valid(d32_hdr), .err_runt(d32_runt), .err_short(d32_short), .err_long(d32_long)
  );

  // Wire image of a header: byte 0 (src high) lands in bits [7:0].
  function automatic logic [63:0] hw(input logic [15:0] s, input logic [15:0] d,
                                     input logic [15:0] l, input logic [15:0] c);
    return {c[7:0], c[15:8], l[7:0], l[15:8], d[7:0], d[15:8], s[7:0], s[15:8]};
  endfunction

  function automatic vec_t row(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input logic h, input logic [63:0] f, input logic ov,
                               input logic [7:0] ok, input logic ol, input logic [2:0] e);
    vec_t r;
    r.data = d; r.keep = k; r.last = l; r.hdr = h; r.fld = f;
    r.ov = ov; r.okeep = ok; r.olast = ol; r.err = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply64(input vec_t r, input string tag);
    @(negedge clk);
    data_slave = r.data; keep_slave = r.keep; last_slave = r.last;
    valid_slave = 1'b1; ready_master = 1'b1;
    #1 chk({tag, " ready_slave"}, 80'(ready_slave), 80'(1'b1));
    @(posedge clk); #1;
    if (r.hdr) exp_fld = r.fld;
    chk({tag, " hdr_valid"}, 80'(hdr_valid), 80'(r.hdr));
    chk({tag, " fields"}, 80'({src_port, dst_address, len_f, checksum}), 80'(exp_fld));
    chk({tag, " errs"}, 80'({err_runt, err_short, err_long}), 80'(r.err));
    chk({tag, " valid_master"}, 80'(valid_master), 80'(r.ov));
    if (r.ov) begin
      chk({tag, " data"}, 80'(data_master), 80'(r.data));
      chk({tag, " keep/last"}, 80'({keep_master, last_master}), 80'({r.okeep, r.olast}));
    end
  endtask

  task automatic apply32(input vec_t r, input string tag);
    @(negedge clk);
    d32_data_s = r.data[31:0]; d32_keep_s = r.keep[3:0]; d32_last_s = r.last;
    d32_valid_s = 1'b1;
    #1 chk({tag, " ready_slave"}, 80'(d32_ready_s), 80'(1'b1));
    @(posedge clk); #1;
    if (r.hdr) exp_fld32 = r.fld;
    chk({tag, " hdr_valid"}, 80'(d32_hdr), 80'(r.hdr));
    chk({tag, " fields"}, 80'({d32_src, d32_dst, d32_len, d32_csum}), 80'(exp_fld32));
    chk({tag, " errs"}, 80'({d32_runt, d32_short, d32_long}), 80'(r.err));
    chk({tag, " valid_master"}, 80'(d32_valid_m), 80'(r.ov));
    if (r.ov) begin
      chk({tag, " data"}, 80'(d32_data_m), 80'(r.data[31:0]));
      chk({tag, " keep/last"}, 80'({d32_keep_m, d32_last_m}), 80'({r.okeep[3:0], r.olast}));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] bp_beat[4];
    logic [72:0] got[$];
    logic [73:0] prev_word;
    logic        prev_stall, tog, acc;
    int          idx, nh;

    // Frame A (test 1), over-length (3), short (4), header-only, drain, partial keep.
    tbl.push_back(row(64'hCDAB_1400_7856_3412, 8'hFF, 0, 1, 64'h1234_5678_0014_ABCD, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(64'h0807_0605_0403_0201, 8'hFF, 0, 0, '0, 1, 8'hFF, 0, 3'b000));
    tbl.push_back(row(64'h100F_0E0D_0C0B_0A09, 8'hFF, 0, 0, '0, 1, 8'hFF, 0, 3'b000));
    tbl.push_back(row(64'h1817_1615_1413_1211, 8'hFF, 1, 0, '0, 1, 8'h0F, 1, 3'b000));
    tbl.push_back(row(hw(16'h0001, 16'h0002, 16'h0008, 16'h0003), 8'hFF, 0, 1, 64'h0001_0002_0008_0003, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(64'hA5A5_0000_1111_2222, 8'hFF, 0, 0, '0, 1, 8'hFF, 1, 3'b001));
    tbl.push_back(row(64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, '0, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(64'hDEAD_BEEF_0000_0002, 8'hFF, 1, 0, '0, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(hw(16'hAAAA, 16'h5555, 16'h0020, 16'hBEEF), 8'hFF, 0, 1, 64'hAAAA_5555_0020_BEEF, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, '0, 1, 8'hFF, 0, 3'b000));
    tbl.push_back(row(64'hFEDC_BA98_7654_3210, 8'hFF, 1, 0, '0, 1, 8'hFF, 1, 3'b010));
    tbl.push_back(row(hw(16'h1111, 16'h2222, 16'h0000, 16'h3333), 8'hFF, 1, 1, 64'h1111_2222_0000_3333, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(hw(16'h4444, 16'h5555, 16'h0004, 16'h6666), 8'hFF, 1, 1, 64'h4444_5555_0004_6666, 0, 8'h00, 0, 3'b010));
    tbl.push_back(row(hw(16'h7777, 16'h8888, 16'h0000, 16'h9999), 8'hFF, 0, 1, 64'h7777_8888_0000_9999, 0, 8'h00, 0, 3'b001));
    tbl.push_back(row(64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 1, 0, '0, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(hw(16'h0ABC, 16'h0DEF, 16'h000C, 16'h1357), 8'hFF, 0, 1, 64'h0ABC_0DEF_000C_1357, 0, 8'h00, 0, 3'b000));
    tbl.push_back(row(64'h1122_3344_5566_7788, 8'hFF, 0, 0, '0, 1, 8'hFF, 0, 3'b000));
    tbl.push_back(row(64'h99AA_BBCC_DDEE_FF00, 8'h07, 1, 0, '0, 1, 8'h07, 1, 3'b000));

    // 32-bit instance: runt on first header beat, then a two-beat header and 6-byte payload.
    tbl32.push_back(row(64'h7856_3412, 8'h0F, 1, 0, '0, 0, 8'h00, 0, 3'b100));
    tbl32.push_back(row(64'h7856_3412, 8'h0F, 0, 0, '0, 0, 8'h00, 0, 3'b000));
    tbl32.push_back(row(64'hCDAB_0600, 8'h0F, 0, 1, 64'h1234_5678_0006_ABCD, 0, 8'h00, 0, 3'b000));
    tbl32.push_back(row(64'h4433_2211, 8'h0F, 0, 0, '0, 1, 8'h0F, 0, 3'b000));
    tbl32.push_back(row(64'h8877_6655, 8'h0F, 1, 0, '0, 1, 8'h03, 1, 3'b000));

    data_slave = '0; keep_slave = '0; valid_slave = 1'b0; last_slave = 1'b0; ready_master = 1'b1;
    d32_data_s = '0; d32_keep_s = '0; d32_valid_s = 1'b0; d32_last_s = 1'b0; d32_ready_m = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs64", 80'({valid_master, last_master, keep_master, hdr_valid, err_runt, err_short, err_long}), 80'(0));
    chk("reset fields64", 80'({src_port, dst_address, len_f, checksum}), 80'(0));
    chk("reset outputs32", 80'({d32_valid_m, d32_hdr, d32_runt, d32_short, d32_long, d32_src, d32_len}), 80'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("post-reset ready_slave", 80'(ready_slave), 80'(1'b1));

    foreach (tbl[i]) apply64(tbl[i], $sformatf("row%0d", i));
    @(negedge clk) valid_slave = 1'b0;
    @(posedge clk); #1;
    chk("idle valid_master", 80'(valid_master), 80'(1'b0));

    // Frame A again with ready_master toggling 1,0,1,0...
    bp_beat[0] = 64'hCDAB_1400_7856_3412;
    bp_beat[1] = 64'h0807_0605_0403_0201;
    bp_beat[2] = 64'h100F_0E0D_0C0B_0A09;
    bp_beat[3] = 64'h1817_1615_1413_1211;
    idx = 0; nh = 0; tog = 1'b1; prev_stall = 1'b0; prev_word = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      ready_master = tog;
      tog = ~tog;
      if (idx < 4) begin
        valid_slave = 1'b1; data_slave = bp_beat[idx]; keep_slave = 8'hFF; last_slave = (idx == 3);
      end else begin
        valid_slave = 1'b0; last_slave = 1'b0;
      end
      #1;
      if (hdr_valid) nh++;
      if (prev_stall)
        chk($sformatf("bp hold c%0d", c), 80'({valid_master, last_master, keep_master, data_master}), 80'(prev_word));
      if (valid_master && !ready_master)
        chk($sformatf("bp ready_slave c%0d", c), 80'(ready_slave), 80'(1'b0));
      if (valid_master && ready_master) got.push_back({last_master, keep_master, data_master});
      prev_stall = valid_master & ~ready_master;
      prev_word  = {valid_master, last_master, keep_master, data_master};
      acc = valid_slave & ready_slave;
      @(posedge clk);
      if (acc) idx++;
    end
    chk("bp beats in", 80'(idx), 80'(4));
    chk("bp beats out", 80'(got.size()), 80'(3));
    chk("bp hdr pulses", 80'(nh), 80'(1));
    chk("bp fields", 80'({src_port, dst_address, len_f, checksum}), 80'(64'h1234_5678_0014_ABCD));
    if (got.size() == 3) begin
      chk("bp beat0", 80'(got[0]), 80'({1'b0, 8'hFF, bp_beat[1]}));
      chk("bp beat1", 80'(got[1]), 80'({1'b0, 8'hFF, bp_beat[2]}));
      chk("bp beat2", 80'(got[2]), 80'({1'b1, 8'h0F, bp_beat[3]}));
    end
    @(negedge clk) ready_master = 1'b1;

    foreach (tbl32[i]) apply32(tbl32[i], $sformatf("w32 row%0d", i));
    @(negedge clk) d32_valid_s = 1'b0;

    // Reset while a payload beat and an err_long pulse are both live.
    apply64(row(hw(16'h0102, 16'h0304, 16'h0008, 16'h0506), 8'hFF, 0, 1, 64'h0102_0304_0008_0506, 0, 8'h00, 0, 3'b000), "rst hdr");
    @(negedge clk);
    data_slave = 64'h0000_0000_0000_0001; keep_slave = 8'hFF; last_slave = 1'b0; valid_slave = 1'b1;
    @(posedge clk); #1;
    chk("rst pre valid_master", 80'(valid_master), 80'(1'b1));
    chk("rst pre err_long", 80'(err_long), 80'(1'b1));
    #2 rst = 1'b0; valid_slave = 1'b0;
    #1;
    chk("rst valid_master", 80'(valid_master), 80'(1'b0));
    chk("rst pulses", 80'({hdr_valid, err_runt, err_short, err_long}), 80'(0));
    chk("rst fields", 80'({src_port, dst_address, len_f, checksum}), 80'(0));
    chk("rst out beat", 80'({last_master, keep_master, data_master}), 80'(0));
    exp_fld = '0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    apply64(row(hw(16'hCAFE, 16'hF00D, 16'h0008, 16'h1234), 8'hFF, 0, 1, 64'hCAFE_F00D_0008_1234, 0, 8'h00, 0, 3'b000), "post hdr");
    apply64(row(64'hFFEE_DDCC_BBAA_9988, 8'hFF, 1, 0, '0, 1, 8'hFF, 1, 3'b000), "post pay");
    @(negedge clk) valid_slave = 1'b0;
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
